// File: rtl/mfe_ctrl.sv
// mfe_ctrl -- frame sequencer for a 3x3 median filter.
//
// Walks every pixel of an IMG_W x IMG_H image in raster order. For each
// pixel it reads the 3x3 neighbourhood from the source image (one pixel per
// cycle), hands the assembled window to an external median datapath, waits
// for the median and writes it to the result memory at the pixel's own
// address. Neighbours that fall outside the image are treated as 0.
//
// Parameters:
//   IMG_W, IMG_H - image size in pixels; IMG_W*IMG_H must equal 2**AW and
//                  IMG_W must be a power of two (so IMG_H is one as well)
//   AW           - address width
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   reset      - asynchronous active-low reset
//   ready      - frame start request, honoured only while idle
//   busy       - frame in progress
//   iaddr      - source image read address (row*IMG_W + col)
//   idata      - source pixel for the current iaddr, captured at the next edge
//   win_valid  - 3x3 window offered to the median datapath
//   win_data   - window, slot k = (dy+1)*3 + (dx+1) in bits [8k+7:8k]
//   win_ready  - datapath accepts the window
//   med_valid  - median result valid (looked at only while waiting for it)
//   med_data   - median result
//   addr       - result memory address
//   data_wr    - result write data
//   wen        - result write enable (1 = write)
module mfe_ctrl #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  output logic          busy,
  output logic [AW-1:0] iaddr,
  input  logic [7:0]    idata,
  output logic          win_valid,
  output logic [71:0]   win_data,
  input  logic          win_ready,
  input  logic          med_valid,
  input  logic [7:0]    med_data,
  output logic [AW-1:0] addr,
  output logic [7:0]    data_wr,
  output logic          wen
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = AW - CW;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  localparam logic [CW-1:0]       C_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0]       R_LAST  = RW'(IMG_H - 1);
  localparam logic signed [AW:0]  IMG_W_S = (AW+1)'(IMG_W);
  localparam logic signed [AW:0]  IMG_H_S = (AW+1)'(IMG_H);
  localparam logic signed [AW:0]  ONE_S   = (AW+1)'(1);

  logic [2:0]    state_q, state_d;
  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic [3:0]    slot_q, slot_d;
  logic [AW-1:0] iaddr_q;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    data_q, data_d;

  // Neighbour coordinates are formed one bit wider than the address and
  // signed, so row/col -1 and row/col == limit are both visible to the
  // border test instead of wrapping into a valid-looking address.
  logic signed [AW:0] dy_s, dx_s, nr_s, nc_s;
  logic               in_bounds;
  logic [AW-1:0]      fetch_addr;

  always_comb begin
    dy_s = '0;
    dx_s = '0;
    case (slot_q)
      4'd0, 4'd1, 4'd2: dy_s = '1;
      4'd6, 4'd7, 4'd8: dy_s = ONE_S;
      default:          dy_s = '0;
    endcase
    case (slot_q)
      4'd0, 4'd3, 4'd6: dx_s = '1;
      4'd2, 4'd5, 4'd8: dx_s = ONE_S;
      default:          dx_s = '0;
    endcase
  end

  assign nr_s = $signed({{(AW+1-RW){1'b0}}, r_q}) + dy_s;
  assign nc_s = $signed({{(AW+1-CW){1'b0}}, c_q}) + dx_s;

  assign in_bounds = !nr_s[AW] && (nr_s < IMG_H_S) &&
                     !nc_s[AW] && (nc_s < IMG_W_S);

  // IMG_W is a power of two, so row*IMG_W+col is a plain concatenation.
  assign fetch_addr = {nr_s[RW-1:0], nc_s[CW-1:0]};

  // Out-of-image slots leave the read address where it was; iaddr_q
  // remembers the last address actually presented.
  assign iaddr = (state_q == S_FETCH && in_bounds) ? fetch_addr : iaddr_q;

  assign busy      = (state_q != S_IDLE);
  assign win_valid = (state_q == S_ISSUE);
  assign wen       = (state_q == S_WRITE);
  assign addr      = addr_q;
  assign data_wr   = data_q;

  // One register per window slot; a slot loads only during its own fetch
  // cycle and otherwise holds, which keeps win_data stable through ISSUE.
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_slot
      logic [7:0] pix_q;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          pix_q <= '0;
        end else if (state_q == S_FETCH && slot_q == 4'(gi)) begin
          pix_q <= in_bounds ? idata : 8'h00;
        end
      end
      assign win_data[8*gi +: 8] = pix_q;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    slot_d  = slot_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (ready) begin
          state_d = S_FETCH;
          r_d     = '0;
          c_d     = '0;
          slot_d  = '0;
        end
      end
      S_FETCH: begin
        if (slot_q == 4'd8) begin
          state_d = S_ISSUE;
          slot_d  = '0;
        end else begin
          slot_d = slot_q + 4'd1;
        end
      end
      S_ISSUE: begin
        if (win_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (med_valid) begin
          data_d  = med_data;
          addr_d  = {r_q, c_q};
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        state_d = S_FETCH;
        slot_d  = '0;
        if (c_q == C_LAST) begin
          c_d = '0;
          if (r_q == R_LAST) begin
            r_d     = '0;
            state_d = S_IDLE;
          end else begin
            r_d = r_q + RW'(1);
          end
        end else begin
          c_d = c_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      c_q     <= '0;
      slot_q  <= '0;
      iaddr_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      slot_q  <= slot_d;
      iaddr_q <= iaddr;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: doc/mfe_ctrl.md
MFE_CTRL -- requirements
Module: mfe_ctrl

Interface
REQ-001 Parameter IMG_W, 128, image width in pixels; power of two.
REQ-002 Parameter IMG_H, 128, image height in pixels.
REQ-003 Parameter AW, 14, address width; the block SHALL require IMG_W*IMG_H = 2^AW.
REQ-004 The block SHALL provide port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-005 The block SHALL provide port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL provide port ready, input, 1 bit: frame start request.
REQ-007 The block SHALL provide port busy, output, 1 bit: frame in progress.
REQ-008 The block SHALL provide port iaddr, output, AW bits: source image read address, row*IMG_W+col.
REQ-009 The block SHALL provide port idata, input, 8 bits: source pixel for the current-cycle iaddr, sampled at the next rising edge.
REQ-010 The block SHALL provide port win_valid, output, 1 bit: 3x3 window offered to the median datapath.
REQ-011 The block SHALL provide port win_data, output, 72 bits: window; slot k=(dy+1)*3+(dx+1) at bits [8k+7:8k].
REQ-012 The block SHALL provide port win_ready, input, 1 bit: datapath accepts the window.
REQ-013 The block SHALL provide port med_valid, input, 1 bit: median result valid.
REQ-014 The block SHALL provide port med_data, input, 8 bits: median result.
REQ-015 The block SHALL provide port addr, output, AW bits: result memory address.
REQ-016 The block SHALL provide port data_wr, output, 8 bits: result write data.
REQ-017 The block SHALL provide port wen, output, 1 bit: 1 = write, 0 = read/idle.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, ISSUE, WAIT, WRITE.
REQ-019 IDLE: busy=0; ready sampled 1 SHALL move to FETCH with pixel (r,c)=(0,0), slot 0, and busy=1 from the next cycle.
REQ-020 FETCH SHALL take exactly 9 cycles, slots 0..8 in order, with iaddr=(r+dy)*IMG_W+(c+dx) and idata stored into that slot.
REQ-021 A slot whose neighbour lies outside the image (row or column <0 or >=limit) SHALL be stored as 0 regardless of idata, with iaddr holding its previous value.
REQ-022 After slot 8, the FSM SHALL enter ISSUE with win_valid=1; win_data SHALL stay stable until win_valid&&win_ready.
REQ-023 The handshake cycle SHALL move to WAIT with win_valid=0 next cycle; win_valid SHALL be 0 outside ISSUE.
REQ-024 WAIT: med_valid=1 SHALL register med_data into data_wr and move to WRITE; med_valid outside WAIT SHALL be ignored.
REQ-025 WRITE SHALL last one cycle with wen=1, addr=r*IMG_W+c, and data_wr=the registered median.
REQ-026 wen SHALL be 0 in every state other than WRITE.
REQ-027 After WRITE, the block SHALL advance c, wrapping to 0 with r+1; the FSM SHALL then re-enter FETCH.
REQ-028 After the WRITE of pixel (IMG_H-1, IMG_W-1), the FSM SHALL return to IDLE with busy=0 the next cycle.
REQ-029 ready SHALL be ignored while busy=1; a new frame SHALL start only from IDLE.
REQ-030 Throughput: with win_ready=1 and med_valid one cycle after the handshake, the block SHALL take 12 cycles per pixel.
REQ-031 Address arithmetic SHALL use AW+1-bit signed intermediates so that the border test detects -1 and IMG_W/IMG_H without wrap-around.

Reset
REQ-032 reset=0 SHALL immediately force state IDLE, busy=0, iaddr=0, win_valid=0, win_data=0, addr=0, data_wr=0, wen=0, r=c=0.
REQ-033 Reset asserted mid-frame SHALL abandon the frame; after release, the block SHALL wait in IDLE for ready.

Verification
REQ-034 Scenario: release reset, hold ready=0 for 10 cycles -> all outputs remain at reset values and busy=0.
REQ-035 Scenario: pulse ready, check pixel (0,0) -> slots 4,5,7,8 read iaddr 0,1,128,129, other slots are 0 in win_data, then wen=1 at addr 0.
REQ-036 Scenario: win_ready low for 5 cycles in ISSUE -> win_valid stays 1, win_data is unchanged, and no write occurs until the handshake.
REQ-037 Scenario: constant image 0x55, full frame -> corners write 0x00, edges and interior write 0x55, busy falls after the addr 16383 write, 16384 writes total.
REQ-038 Scenario: pulse ready while busy=1 -> no restart and the pixel sequence is unchanged.
REQ-039 Scenario: assert reset during pixel 200's FETCH -> outputs go to reset values at once, and a new ready restarts at pixel 0.
